mul_div_unit: RTL

- Iterative RV32M multiply/divide unit. It sits downstream of the ALU operand muxes (src_a mux, src_b mux) in parallel with the ALU.
- It consumes the same selected operands and returns a 32-bit result to the writeback path.
- Multi-cycle: it stalls the pipeline via busy until done pulses. It aborts on kill (pipeline flush).

---
 rtl/mul_div_if.sv | 22 ++
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mul_div_if.sv
// Handshake and operand bundle between the operand muxes / writeback path
// and the iterative RV32M multiply/divide unit.
interface mul_div_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, src_a, src_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src_a, src_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied on the final step.
module mul_div_unit (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] hi_reg, hi_next;       // product high half / partial remainder
    logic [31:0] lo_reg, lo_next;       // multiplier bits / dividend-quotient
    logic [31:0] opnd_reg, opnd_next;   // multiplicand / divisor magnitude
    logic        neg_res_reg, neg_res_next;
    logic        neg_rem_reg, neg_rem_next;
    logic [31:0] result_reg, result_next;

    // operand decode at the start edge
    logic        a_signed, b_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic        div_by_zero, div_overflow;

    // one iteration of the datapath
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [31:0] iter_hi, iter_lo;
    logic [63:0] prod_mag, prod_fix;
    logic [31:0] quot_fix, rem_fix, final_value;

    always_comb begin
        a_signed     = !(bus.op == 3'd3 || bus.op == 3'd5 || bus.op == 3'd7);
        b_signed     = (bus.op == 3'd0 || bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6);
        sign_a       = a_signed & bus.src_a[31];
        sign_b       = b_signed & bus.src_b[31];
        mag_a        = sign_a ? (~bus.src_a + 32'd1) : bus.src_a;
        mag_b        = sign_b ? (~bus.src_b + 32'd1) : bus.src_b;
        div_by_zero  = bus.op[2] && (bus.src_b == 32'd0);
        div_overflow = bus.op[2] && !bus.op[0] &&
                       (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);
    end

    always_comb begin
        // multiply: add multiplicand on lo[0], then shift the 64-bit pair right
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        // divide: shift in next dividend bit, subtract divisor if it fits
        div_shift = {hi_reg, lo_reg[31]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_ge    = !div_diff[32];
        if (op_reg[2]) begin
            iter_hi = div_ge ? div_diff[31:0] : div_shift[31:0];
            iter_lo = {lo_reg[30:0], div_ge};
        end else begin
            iter_hi = mul_sum[32:1];
            iter_lo = {mul_sum[0], lo_reg[31:1]};
        end
        prod_mag = {iter_hi, iter_lo};
        prod_fix = neg_res_reg ? (~prod_mag + 64'd1) : prod_mag;
        quot_fix = neg_res_reg ? (~iter_lo + 32'd1) : iter_lo;
        rem_fix  = neg_rem_reg ? (~iter_hi + 32'd1) : iter_hi;
        if (op_reg[2])
            final_value = op_reg[1] ? rem_fix : quot_fix;
        else
            final_value = (op_reg[1:0] == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        op_next      = op_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        opnd_next    = opnd_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        result_next  = result_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_next      = bus.op;
                    count_next   = 5'd0;
                    hi_next      = 32'd0;
                    lo_next      = bus.op[2] ? mag_a : mag_b;
                    opnd_next    = bus.op[2] ? mag_b : mag_a;
                    neg_res_next = sign_a ^ sign_b;
                    neg_rem_next = sign_a;
                    if (div_by_zero) begin
                        result_next = bus.op[1] ? bus.src_a : 32'hFFFF_FFFF;
                        state_next  = DONE;
                    end else if (div_overflow) begin
                        result_next = bus.op[1] ? 32'd0 : 32'h8000_0000;
                        state_next  = DONE;
                    end else begin
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_next = IDLE;
                end else begin
                    hi_next    = iter_hi;
                    lo_next    = iter_lo;
                    count_next = count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        result_next = final_value;
                        state_next  = DONE;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= 5'd0;
            op_reg      <= 3'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            opnd_reg    <= 32'd0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= 32'd0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            op_reg      <= op_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            opnd_reg    <= opnd_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            result_reg  <= result_next;
        end
    end

    // a kill in DONE suppresses the pulse in that same cycle
    assign bus.busy   = (state_reg == CALC);
    assign bus.done   = (state_reg == DONE) && !bus.kill;
    assign bus.result = result_reg;
endmodule
